// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Supervises a set of PLL lock flags from the free-running crystal clock.
// It pulses the PLL reset, debounces the combined lock, then releases the
// per-domain resets one at a time. A lock loss after release has started
// pulls every domain back into reset and waits for the PLL to relock. A PLL
// that never locks is re-reset after a timeout.
//
// Ports
//   clkin      : crystal clock, the only clock in the block
//   rst_n      : asynchronous active-low reset
//   lock       : raw PLL lock flags, asynchronous to clkin
//   pll_rst    : active-high reset to all PLLs (registered)
//   dom_rst_n  : active-low domain resets, released in index order (registered)
//   all_locked : high only while every domain is released and lock holds
//   loss_cnt   : saturating count of lock losses after release began
//   retry_cnt  : saturating count of lock timeouts
//   state      : debug encoding PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3
module pll_lock_supervisor #(
    parameter int                N_PLL       = 3,
    parameter logic [N_PLL-1:0]  LOCK_MASK   = '1,
    parameter int                N_DOM       = 4,
    parameter int                STABLE_CYC  = 1024,
    parameter int                STAGGER_CYC = 8,
    parameter int                PLL_RST_CYC = 16,
    parameter int                TIMEOUT_CYC = 1048576,
    parameter int                CNT_W       = 8
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic [N_PLL-1:0]  lock,
    output logic              pll_rst,
    output logic [N_DOM-1:0]  dom_rst_n,
    output logic              all_locked,
    output logic [CNT_W-1:0]  loss_cnt,
    output logic [CNT_W-1:0]  retry_cnt,
    output logic [2:0]        state
);

    localparam int PR_W  = (PLL_RST_CYC > 1) ? $clog2(PLL_RST_CYC) : 1;
    localparam int STB_W = (STABLE_CYC  > 1) ? $clog2(STABLE_CYC)  : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int STG_W = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;

    localparam logic [PR_W-1:0]  PR_LAST   = PR_W'(PLL_RST_CYC - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(STAGGER_CYC - 1);
    localparam logic [N_DOM-1:0] DOM_FIRST = N_DOM'(1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3
    } state_t;

    state_t             st, st_nxt;
    logic [N_PLL-1:0]   sync_p0, sync_p1;
    logic               lock_s;
    logic [PR_W-1:0]    pr_cnt, pr_nxt;
    logic [STB_W-1:0]   stb_cnt, stb_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic [STG_W-1:0]   stg_cnt, stg_nxt;
    logic               pll_rst_nxt;
    logic [N_DOM-1:0]   dom_nxt;
    logic               all_nxt;
    logic [CNT_W-1:0]   loss_nxt, retry_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Masked-out lock inputs count as permanently locked.
    assign lock_s = &(sync_p1 | ~LOCK_MASK);
    assign state  = st;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            st         <= S_PLL_RST;
            pr_cnt     <= '0;
            stb_cnt    <= '0;
            tmo_cnt    <= '0;
            stg_cnt    <= '0;
            pll_rst    <= 1'b1;
            dom_rst_n  <= '0;
            all_locked <= 1'b0;
            loss_cnt   <= '0;
            retry_cnt  <= '0;
        end else begin
            // stage p0 -> p1: two-flop lock synchroniser
            sync_p0    <= lock;
            sync_p1    <= sync_p0;
            st         <= st_nxt;
            pr_cnt     <= pr_nxt;
            stb_cnt    <= stb_nxt;
            tmo_cnt    <= tmo_nxt;
            stg_cnt    <= stg_nxt;
            pll_rst    <= pll_rst_nxt;
            dom_rst_n  <= dom_nxt;
            all_locked <= all_nxt;
            loss_cnt   <= loss_nxt;
            retry_cnt  <= retry_nxt;
        end
    end

    // All outputs are computed here and registered above, so each output
    // changes on the same edge as the state it belongs to and never glitches.
    always_comb begin
        st_nxt      = st;
        pr_nxt      = pr_cnt;
        stb_nxt     = stb_cnt;
        tmo_nxt     = tmo_cnt;
        stg_nxt     = stg_cnt;
        pll_rst_nxt = pll_rst;
        dom_nxt     = dom_rst_n;
        all_nxt     = all_locked;
        loss_nxt    = loss_cnt;
        retry_nxt   = retry_cnt;
        case (st)
            S_PLL_RST: begin
                pll_rst_nxt = 1'b1;
                dom_nxt     = '0;
                all_nxt     = 1'b0;
                if (pr_cnt == PR_LAST) begin
                    st_nxt      = S_WAIT_LOCK;
                    pll_rst_nxt = 1'b0;
                    pr_nxt      = '0;
                    stb_nxt     = '0;
                    tmo_nxt     = '0;
                end else begin
                    pr_nxt = pr_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // Release wins over timeout when both land on one cycle.
                if (lock_s && (stb_cnt == STB_LAST)) begin
                    st_nxt  = S_RELEASE;
                    dom_nxt = DOM_FIRST;
                    stg_nxt = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    st_nxt      = S_PLL_RST;
                    pll_rst_nxt = 1'b1;
                    pr_nxt      = '0;
                    retry_nxt   = sat_inc(retry_cnt);
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                    stb_nxt = lock_s ? stb_cnt + 1'b1 : '0;
                end
            end
            S_RELEASE, S_RUN: begin
                // The PLL is left to relock on its own after a loss.
                if (!lock_s) begin
                    st_nxt   = S_WAIT_LOCK;
                    dom_nxt  = '0;
                    all_nxt  = 1'b0;
                    stb_nxt  = '0;
                    tmo_nxt  = '0;
                    loss_nxt = sat_inc(loss_cnt);
                end else if (st == S_RELEASE) begin
                    if (stg_cnt == STG_LAST) begin
                        stg_nxt = '0;
                        if (dom_rst_n[N_DOM-1]) begin
                            st_nxt  = S_RUN;
                            all_nxt = 1'b1;
                        end else begin
                            // Thermometer fill: release the next index.
                            dom_nxt = (dom_rst_n << 1) | DOM_FIRST;
                        end
                    end else begin
                        stg_nxt = stg_cnt + 1'b1;
                    end
                end
            end
            default: begin
                st_nxt      = S_PLL_RST;
                pll_rst_nxt = 1'b1;
                dom_nxt     = '0;
                all_nxt     = 1'b0;
                pr_nxt      = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int N_PLL       = 3;
    localparam int N_DOM       = 3;
    localparam int STABLE_CYC  = 4;
    localparam int STAGGER_CYC = 2;
    localparam int PLL_RST_CYC = 3;
    localparam int TIMEOUT_CYC = 20;
    localparam int CNT_W       = 2;
    localparam int SAT_MAX     = (1 << CNT_W) - 1;
    localparam logic [N_PLL-1:0] MASK_A = 3'b111;
    localparam logic [N_PLL-1:0] MASK_B = 3'b011;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic             rst_a, rst_b;
    logic [N_PLL-1:0] lock_a, lock_b;
    logic             pll_rst_a, pll_rst_b;
    logic [N_DOM-1:0] dom_a, dom_b;
    logic             all_a, all_b;
    logic [CNT_W-1:0] loss_a, loss_b, retry_a, retry_b;
    logic [2:0]       state_a, state_b;

    pll_lock_supervisor #(
        .N_PLL(N_PLL), .LOCK_MASK(MASK_A), .N_DOM(N_DOM), .STABLE_CYC(STABLE_CYC),
        .STAGGER_CYC(STAGGER_CYC), .PLL_RST_CYC(PLL_RST_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut_a (
        .clkin(clkin), .rst_n(rst_a), .lock(lock_a), .pll_rst(pll_rst_a),
        .dom_rst_n(dom_a), .all_locked(all_a), .loss_cnt(loss_a),
        .retry_cnt(retry_a), .state(state_a)
    );

    pll_lock_supervisor #(
        .N_PLL(N_PLL), .LOCK_MASK(MASK_B), .N_DOM(N_DOM), .STABLE_CYC(STABLE_CYC),
        .STAGGER_CYC(STAGGER_CYC), .PLL_RST_CYC(PLL_RST_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut_b (
        .clkin(clkin), .rst_n(rst_b), .lock(lock_b), .pll_rst(pll_rst_b),
        .dom_rst_n(dom_b), .all_locked(all_b), .loss_cnt(loss_b),
        .retry_cnt(retry_b), .state(state_b)
    );

    int n_checks = 0;
    int n_err    = 0;
    int e        = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, time spent in phase, length of the current
    // run of consecutive locked cycles, and the event counters.
    int               m_ph[2], m_t[2], m_run[2], m_loss[2], m_retry[2];
    logic [N_PLL-1:0] m_s1[2], m_s2[2];

    task automatic model_reset(input int k);
        m_ph[k] = 0; m_t[k] = 0; m_run[k] = 0;
        m_loss[k] = 0; m_retry[k] = 0;
        m_s1[k] = '0; m_s2[k] = '0;
    endtask

    task automatic model_step(input int k, input logic [N_PLL-1:0] lk,
                              input logic [N_PLL-1:0] mask);
        bit ls;
        ls = &(m_s2[k] | ~mask);
        m_s2[k] = m_s1[k];
        m_s1[k] = lk;
        if (m_ph[k] == 0) begin
            m_t[k]++;
            if (m_t[k] == PLL_RST_CYC) begin
                m_ph[k] = 1; m_t[k] = 0; m_run[k] = 0;
            end
        end else if (m_ph[k] == 1) begin
            m_t[k]++;
            m_run[k] = ls ? m_run[k] + 1 : 0;
            if (m_run[k] == STABLE_CYC) begin
                m_ph[k] = 2; m_t[k] = 0;
            end else if (m_t[k] == TIMEOUT_CYC) begin
                m_ph[k] = 0; m_t[k] = 0;
                if (m_retry[k] < SAT_MAX) m_retry[k]++;
            end
        end else if (!ls) begin
            m_ph[k] = 1; m_t[k] = 0; m_run[k] = 0;
            if (m_loss[k] < SAT_MAX) m_loss[k]++;
        end else begin
            m_t[k]++;
            if (m_ph[k] == 2 && m_t[k] == N_DOM * STAGGER_CYC) m_ph[k] = 3;
        end
    endtask

    function automatic int exp_dom(input int k);
        int n;
        n = 0;
        if (m_ph[k] == 3) n = N_DOM;
        else if (m_ph[k] == 2) begin
            n = 1 + m_t[k] / STAGGER_CYC;
            if (n > N_DOM) n = N_DOM;
        end
        return (1 << n) - 1;
    endfunction

    always @(posedge clkin or negedge rst_a)
        if (!rst_a) model_reset(0); else model_step(0, lock_a, MASK_A);

    always @(posedge clkin or negedge rst_b)
        if (!rst_b) model_reset(1); else model_step(1, lock_b, MASK_B);

    always @(negedge clkin) begin
        chk("a_pll_rst", int'(pll_rst_a), int'(m_ph[0] == 0));
        chk("a_dom",     int'(dom_a),     exp_dom(0));
        chk("a_all",     int'(all_a),     int'(m_ph[0] == 3));
        chk("a_loss",    int'(loss_a),    m_loss[0]);
        chk("a_retry",   int'(retry_a),   m_retry[0]);
        chk("a_state",   int'(state_a),   m_ph[0]);
        chk("b_pll_rst", int'(pll_rst_b), int'(m_ph[1] == 0));
        chk("b_dom",     int'(dom_b),     exp_dom(1));
        chk("b_all",     int'(all_b),     int'(m_ph[1] == 3));
        chk("b_loss",    int'(loss_b),    m_loss[1]);
        chk("b_retry",   int'(retry_b),   m_retry[1]);
        chk("b_state",   int'(state_b),   m_ph[1]);
    end

    task automatic tick_to(input int target);
        while (e < target) begin
            @(posedge clkin);
            #2;
            e++;
        end
    endtask

    // Edge 0 is the first edge after rst is dropped; rst releases just after it.
    task automatic start_a(input logic [N_PLL-1:0] lk);
        rst_a  = 1'b0;
        lock_a = lk;
        @(posedge clkin);
        #1 rst_a = 1'b1;
        #1 e = 0;
    endtask

    task automatic start_b(input logic [N_PLL-1:0] lk);
        rst_b  = 1'b0;
        lock_b = lk;
        @(posedge clkin);
        #1 rst_b = 1'b1;
        #1 e = 0;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        lock_a = '0;  lock_b = '0;
        @(posedge clkin);
        #1;
        chk("rst_pll_rst", int'(pll_rst_a), 1);
        chk("rst_dom",     int'(dom_a),     0);
        chk("rst_all",     int'(all_a),     0);
        chk("rst_loss",    int'(loss_a),    0);
        chk("rst_retry",   int'(retry_a),   0);
        chk("rst_state",   int'(state_a),   0);

        // Power-up with all locks present.
        start_a(3'b111);
        tick_to(2);  chk("pu_pll_rst_e2", int'(pll_rst_a), 1); chk("pu_state_e2", int'(state_a), 0);
        tick_to(3);  chk("pu_pll_rst_e3", int'(pll_rst_a), 0); chk("pu_state_e3", int'(state_a), 1);
        tick_to(6);  chk("pu_dom_e6",  int'(dom_a), 0);
        tick_to(7);  chk("pu_dom_e7",  int'(dom_a), 1); chk("pu_state_e7", int'(state_a), 2);
        tick_to(9);  chk("pu_dom_e9",  int'(dom_a), 3);
        tick_to(11); chk("pu_dom_e11", int'(dom_a), 7); chk("pu_all_e11", int'(all_a), 0);
        tick_to(12); chk("pu_all_e12", int'(all_a), 0);
        tick_to(13); chk("pu_all_e13", int'(all_a), 1); chk("pu_state_e13", int'(state_a), 3);
        tick_to(16);

        // One-cycle lock glitch while debouncing.
        start_a(3'b111);
        tick_to(4);  lock_a[1] = 1'b0;
        tick_to(5);  lock_a = 3'b111;
        tick_to(7);  chk("gl_dom_e7",  int'(dom_a), 0); chk("gl_state_e7", int'(state_a), 1);
        tick_to(10); chk("gl_dom_e10", int'(dom_a), 0);
        tick_to(11); chk("gl_dom_e11", int'(dom_a), 1); chk("gl_loss", int'(loss_a), 0);
        tick_to(17); chk("gl_all_e17", int'(all_a), 1);

        // Loss of lock in RUN, then relock.
        tick_to(20); lock_a[2] = 1'b0;
        tick_to(22); chk("ls_dom_e22", int'(dom_a), 7); chk("ls_state_e22", int'(state_a), 3);
        tick_to(23);
        chk("ls_dom_e23",   int'(dom_a),     0);
        chk("ls_all_e23",   int'(all_a),     0);
        chk("ls_loss_e23",  int'(loss_a),    1);
        chk("ls_state_e23", int'(state_a),   1);
        chk("ls_pll_e23",   int'(pll_rst_a), 0);
        lock_a = 3'b111;
        tick_to(28); chk("rl_dom_e28", int'(dom_a), 0);
        tick_to(29); chk("rl_dom_e29", int'(dom_a), 1); chk("rl_state_e29", int'(state_a), 2);

        // Asynchronous reset in the middle of RELEASE, between edges.
        tick_to(30);
        #1 rst_a = 1'b0;
        #1;
        chk("ar_pll_rst", int'(pll_rst_a), 1);
        chk("ar_dom",     int'(dom_a),     0);
        chk("ar_all",     int'(all_a),     0);
        chk("ar_loss",    int'(loss_a),    0);
        chk("ar_retry",   int'(retry_a),   0);
        chk("ar_state",   int'(state_a),   0);

        // PLL never locks: periodic re-reset and saturating retry count.
        start_a(3'b000);
        tick_to(22); chk("to_state_e22", int'(state_a), 1); chk("to_retry_e22", int'(retry_a), 0);
        tick_to(23); chk("to_pll_e23", int'(pll_rst_a), 1); chk("to_retry_e23", int'(retry_a), 1);
        tick_to(25); chk("to_pll_e25", int'(pll_rst_a), 1);
        tick_to(26); chk("to_pll_e26", int'(pll_rst_a), 0); chk("to_state_e26", int'(state_a), 1);
        tick_to(46); chk("to_retry_e46", int'(retry_a), 2); chk("to_pll_e46", int'(pll_rst_a), 1);
        tick_to(69); chk("to_retry_e69", int'(retry_a), 3);
        tick_to(91); chk("to_pll_e91", int'(pll_rst_a), 0);
        tick_to(92); chk("to_retry_e92", int'(retry_a), 3); chk("to_pll_e92", int'(pll_rst_a), 1);

        // Masked lock[2] tied low, then toggled: no effect on the sequence.
        start_b(3'b011);
        tick_to(3);  chk("mk_state_e3", int'(state_b), 1);
        tick_to(7);  chk("mk_dom_e7",  int'(dom_b), 1);
        tick_to(11); chk("mk_dom_e11", int'(dom_b), 7);
        tick_to(13); chk("mk_all_e13", int'(all_b), 1); chk("mk_state_e13", int'(state_b), 3);
        for (int i = 14; i < 34; i++) begin
            tick_to(i);
            lock_b[2] = ~lock_b[2];
        end
        tick_to(36);
        chk("mk_all_e36",   int'(all_b),   1);
        chk("mk_loss_e36",  int'(loss_b),  0);
        chk("mk_dom_e36",   int'(dom_b),   7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
